// File: rtl/fractal_pixel_engine_if.sv
// Pixel stream from the fractal engine to the stream packer: valid/ready with rgb and sof/eol sideband.
interface fractal_pixel_engine_if;
    logic       valid;
    logic       ready;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;

    modport master (output valid, r, g, b, sof, eol, input ready);
    modport slave  (input valid, r, g, b, sof, eol, output ready);
endinterface

// File: rtl/fractal_pixel_engine.sv
// Raster-order escape-time fractal generator (Mandelbrot / Julia / optional Burning Ship) with RGB stream out.
// Define FRACTAL_BURNING_SHIP_EN to build the |zr|,|zi| datapath for cfg_mode_i=2; otherwise mode 2 is Mandelbrot.
//
// state | meaning
// IDLE  | waiting for enable_i; latches cfg into shadow registers on start
// INIT  | loads z and c for the current pixel, clears the iteration count
// ITER  | one escape test / iteration per cycle
// EMIT  | pixel presented on the stream, held until accepted
module fractal_pixel_engine #(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ITER_W    = 8
) (
    input  logic                     aclk_i,
    input  logic                     aresetn_i,
    input  logic                     enable_i,
    input  logic [1:0]               cfg_mode_i,
    input  logic signed [DATA_W-1:0] cfg_re_start_i,
    input  logic signed [DATA_W-1:0] cfg_im_start_i,
    input  logic signed [DATA_W-1:0] cfg_re_step_i,
    input  logic signed [DATA_W-1:0] cfg_im_step_i,
    input  logic signed [DATA_W-1:0] cfg_jul_re_i,
    input  logic signed [DATA_W-1:0] cfg_jul_im_i,
    input  logic [ITER_W-1:0]        cfg_max_iter_i,
    input  logic [7:0]               cfg_pal_g_i,
    input  logic [7:0]               cfg_pal_b_i,
    fractal_pixel_engine_if.master   m_if,
    output logic                     frame_done_o,
    output logic                     busy_o
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int PW = 2 * DATA_W;

    // 4.0 in the squared-magnitude scale (2*FRAC_BITS fractional bits)
    localparam logic signed [PW:0] ESC_LIM =
        {{(PW - 2*FRAC_BITS - 2){1'b0}}, 3'b100, {(2*FRAC_BITS){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t state_q;

    logic [1:0]               mode_q;
    logic signed [DATA_W-1:0] re_start_q;
    logic signed [DATA_W-1:0] re_step_q;
    logic signed [DATA_W-1:0] im_step_q;
    logic signed [DATA_W-1:0] jul_re_q;
    logic signed [DATA_W-1:0] jul_im_q;
    logic [ITER_W-1:0]        max_iter_q;
    logic [7:0]               pal_g_q;
    logic [7:0]               pal_b_q;

    logic [XW-1:0]            x_q;
    logic [YW-1:0]            y_q;
    logic signed [DATA_W-1:0] re_q;
    logic signed [DATA_W-1:0] im_q;

    logic signed [DATA_W-1:0] zr_q;
    logic signed [DATA_W-1:0] zi_q;
    logic signed [DATA_W-1:0] cr_q;
    logic signed [DATA_W-1:0] ci_q;
    logic [ITER_W-1:0]        k_q;

    logic                     valid_q;
    logic [7:0]               r_q;
    logic [7:0]               g_q;
    logic [7:0]               b_q;
    logic                     sof_q;
    logic                     eol_q;
    logic                     frame_done_q;
    logic                     busy_q;

    logic signed [PW-1:0]     zr2;
    logic signed [PW-1:0]     zi2;
    logic signed [PW-1:0]     zrzi;
    logic signed [PW:0]       mag;
    logic                     escape;
    logic                     at_limit;
    logic signed [DATA_W-1:0] zr_d;
    logic signed [DATA_W-1:0] zi_d;
    logic                     is_julia;
    logic                     last_x;
    logic                     last_y;

`ifdef FRACTAL_BURNING_SHIP_EN
    logic                     ship;
    logic signed [DATA_W-1:0] abs_zr;
    logic signed [DATA_W-1:0] abs_zi;

    always_comb begin
        ship   = (mode_q == 2'd2);
        abs_zr = (ship && zr_q[DATA_W-1]) ? -zr_q : zr_q;
        abs_zi = (ship && zi_q[DATA_W-1]) ? -zi_q : zi_q;
    end

    assign zrzi = abs_zr * abs_zi;
`else
    assign zrzi = zr_q * zi_q;
`endif

    assign zr2      = zr_q * zr_q;
    assign zi2      = zi_q * zi_q;
    assign mag      = zr2 + zi2;
    assign escape   = (mag > ESC_LIM);
    assign at_limit = (k_q == max_iter_q);
    // Wrap on overflow: only the low DATA_W bits of the shifted products survive
    assign zr_d     = DATA_W'((zr2 - zi2) >>> FRAC_BITS) + cr_q;
    assign zi_d     = DATA_W'((zrzi <<< 1) >>> FRAC_BITS) + ci_q;
    assign is_julia = (mode_q == 2'd1);
    assign last_x   = (x_q == XW'(X_SIZE - 1));
    assign last_y   = (y_q == YW'(Y_SIZE - 1));

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            re_start_q   <= '0;
            re_step_q    <= '0;
            im_step_q    <= '0;
            jul_re_q     <= '0;
            jul_im_q     <= '0;
            max_iter_q   <= '0;
            pal_g_q      <= '0;
            pal_b_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            re_q         <= '0;
            im_q         <= '0;
            zr_q         <= '0;
            zi_q         <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            k_q          <= '0;
            valid_q      <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        mode_q     <= cfg_mode_i;
                        re_start_q <= cfg_re_start_i;
                        re_step_q  <= cfg_re_step_i;
                        im_step_q  <= cfg_im_step_i;
                        jul_re_q   <= cfg_jul_re_i;
                        jul_im_q   <= cfg_jul_im_i;
                        max_iter_q <= cfg_max_iter_i;
                        pal_g_q    <= cfg_pal_g_i;
                        pal_b_q    <= cfg_pal_b_i;
                        re_q       <= cfg_re_start_i;
                        im_q       <= cfg_im_start_i;
                        x_q        <= '0;
                        y_q        <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (is_julia) begin
                        zr_q <= re_q;
                        zi_q <= im_q;
                        cr_q <= jul_re_q;
                        ci_q <= jul_im_q;
                    end else begin
                        zr_q <= '0;
                        zi_q <= '0;
                        cr_q <= re_q;
                        ci_q <= im_q;
                    end
                    k_q     <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    // Escape has priority over the limit, so a pixel escaping on k==max is still coloured
                    if (escape || at_limit) begin
                        valid_q <= 1'b1;
                        r_q     <= escape ? 8'(k_q) : 8'd0;
                        g_q     <= escape ? 8'(k_q * pal_g_q) : 8'd0;
                        b_q     <= escape ? 8'(k_q * pal_b_q) : 8'd0;
                        sof_q   <= (x_q == '0) && (y_q == '0);
                        eol_q   <= last_x;
                        state_q <= S_EMIT;
                    end else begin
                        zr_q <= zr_d;
                        zi_q <= zi_d;
                        k_q  <= k_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (m_if.ready) begin
                        valid_q <= 1'b0;
                        sof_q   <= 1'b0;
                        eol_q   <= 1'b0;
                        r_q     <= '0;
                        g_q     <= '0;
                        b_q     <= '0;
                        if (last_x) begin
                            x_q  <= '0;
                            re_q <= re_start_q;
                            if (last_y) begin
                                y_q          <= '0;
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                y_q     <= y_q + 1'b1;
                                im_q    <= im_q + im_step_q;
                                state_q <= S_INIT;
                            end
                        end else begin
                            x_q     <= x_q + 1'b1;
                            re_q    <= re_q + re_step_q;
                            state_q <= S_INIT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_if.valid   = valid_q;
    assign m_if.r       = r_q;
    assign m_if.g       = g_q;
    assign m_if.b       = b_q;
    assign m_if.sof     = sof_q;
    assign m_if.eol     = eol_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;

endmodule
